// File: rtl/life_queue.sv
// Circular queue of {value, life} entries; serving an entry decrements its life and retires it at zero.
// Optional macro LIFE_QUEUE_DROP_ZERO_EN discards incoming entries whose life is already zero.
module life_queue #(
    parameter int DATA_W   = 16,
    parameter int LIFE_W   = 16,
    parameter int ADDR_LEN = 2,
    parameter int MODE     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq,
    input  logic                       deq,
    input  logic [DATA_W+LIFE_W-1:0]   data_in,
    output logic [DATA_W+LIFE_W-1:0]   data_out,
    output logic                       out_valid,
    output logic                       full,
    output logic                       empty,
    output logic [ADDR_LEN:0]          count,
    output logic                       drop
);

    localparam int                ENTRY_W    = DATA_W + LIFE_W;
    localparam int                DEPTH      = 2 ** ADDR_LEN;
    localparam logic [ADDR_LEN:0] FULL_COUNT = (ADDR_LEN + 1)'(DEPTH);

    function automatic logic [LIFE_W-1:0] satDec(input logic [LIFE_W-1:0] life);
        return (life == '0) ? '0 : life - LIFE_W'(1);
    endfunction

    logic [ENTRY_W-1:0]  r_mem [DEPTH];
    logic [ADDR_LEN-1:0] r_rdPtr;
    logic [ADDR_LEN-1:0] r_wrPtr;
    logic [ADDR_LEN:0]   r_count;
    logic [ENTRY_W-1:0]  r_dataOut;
    logic                r_outValid;
    logic                r_drop;

    logic                w_full;
    logic                w_empty;
    logic [DATA_W-1:0]   w_inVal;
    logic [LIFE_W-1:0]   w_inLife;
    logic [LIFE_W-1:0]   w_inDec;
    logic [DATA_W-1:0]   w_headVal;
    logic [LIFE_W-1:0]   w_headLife;
    logic [LIFE_W-1:0]   w_headDec;
    logic                w_headLive;
    logic                w_enqValid;
    logic                w_bypass;
    logic                w_bypassStore;
    logic                w_serveHead;
    logic                w_retire;
    logic                w_recycle;
    logic                w_inPlace;
    logic                w_enqReq;
    logic                w_enqAccept;
    logic                w_dropNow;
    logic                w_push;
    logic [1:0]          w_wrAdv;
    logic [ADDR_LEN-1:0] w_newPtr;
    logic [ENTRY_W-1:0]  w_newEntry;

    assign w_full     = (r_count == FULL_COUNT);
    assign w_empty    = (r_count == '0);
    assign w_inVal    = data_in[ENTRY_W-1:LIFE_W];
    assign w_inLife   = data_in[LIFE_W-1:0];
    assign w_inDec    = satDec(w_inLife);
    assign w_headVal  = r_mem[r_rdPtr][ENTRY_W-1:LIFE_W];
    assign w_headLife = r_mem[r_rdPtr][LIFE_W-1:0];
    assign w_headDec  = satDec(w_headLife);
    assign w_headLive = (w_headDec != '0);

`ifdef LIFE_QUEUE_DROP_ZERO_EN
    assign w_enqValid = enq & (w_inLife != '0);
`else
    assign w_enqValid = enq;
`endif

    // An empty queue serves the incoming entry directly; it is kept only if life remains.
    assign w_bypass      = w_empty & deq & w_enqValid;
    assign w_bypassStore = w_bypass & (w_inDec != '0);
    assign w_serveHead   = deq & ~w_empty;
    assign w_retire      = w_serveHead & ~w_headLive;
    assign w_recycle     = w_serveHead & w_headLive & (MODE == 1);
    assign w_inPlace     = w_serveHead & w_headLive & (MODE != 1);

    // A full queue only takes a new entry when the same-cycle serve frees the head slot.
    assign w_enqReq    = w_enqValid & ~w_bypass;
    assign w_enqAccept = w_enqReq & (~w_full | w_retire);
    assign w_dropNow   = w_enqReq & ~w_enqAccept;
    assign w_push      = w_enqAccept | w_bypassStore;

    assign w_wrAdv    = {1'b0, w_recycle} + {1'b0, w_push};
    assign w_newPtr   = w_recycle ? r_wrPtr + ADDR_LEN'(1) : r_wrPtr;
    assign w_newEntry = w_bypass ? {w_inVal, w_inDec} : data_in;

    // Recycled head lands at the tail before any new entry written in the same cycle.
    always_ff @(posedge clk) begin
        if (w_inPlace) begin
            r_mem[r_rdPtr] <= {w_headVal, w_headDec};
        end
        if (w_recycle) begin
            r_mem[r_wrPtr] <= {w_headVal, w_headDec};
        end
        if (w_push) begin
            r_mem[w_newPtr] <= w_newEntry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
            r_count    <= '0;
            r_dataOut  <= '0;
            r_outValid <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            if (w_retire | w_recycle) begin
                r_rdPtr <= r_rdPtr + ADDR_LEN'(1);
            end
            r_wrPtr    <= r_wrPtr + ADDR_LEN'(w_wrAdv);
            r_count    <= r_count + {{ADDR_LEN{1'b0}}, w_push} - {{ADDR_LEN{1'b0}}, w_retire};
            r_outValid <= w_bypass | w_serveHead;
            r_drop     <= w_dropNow;
            if (w_bypass) begin
                r_dataOut <= {w_inVal, w_inDec};
            end else if (w_serveHead) begin
                r_dataOut <= {w_headVal, w_headDec};
            end
        end
    end

    assign data_out  = r_dataOut;
    assign out_valid = r_outValid;
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign drop      = r_drop;

endmodule

// File: tb/tb_life_queue.sv
// Directed bench for life_queue: one STICKY and one ROTATE instance share the same stimulus.
module tb_life_queue;

    localparam int DATA_W   = 16;
    localparam int LIFE_W   = 16;
    localparam int ADDR_LEN = 2;
    localparam int ENTRY_W  = DATA_W + LIFE_W;

    logic               clk;
    logic               rst;
    logic               enq;
    logic               deq;
    logic [ENTRY_W-1:0] dataIn;

    logic [ENTRY_W-1:0] dataOut0, dataOut1;
    logic               outValid0, outValid1;
    logic               full0, full1;
    logic               empty0, empty1;
    logic [ADDR_LEN:0]  count0, count1;
    logic               drop0, drop1;

    int checkCount = 0;
    int failCount  = 0;

    life_queue #(.DATA_W(DATA_W), .LIFE_W(LIFE_W), .ADDR_LEN(ADDR_LEN), .MODE(0)) u_sticky (
        .clk(clk), .rst(rst), .enq(enq), .deq(deq), .data_in(dataIn),
        .data_out(dataOut0), .out_valid(outValid0), .full(full0), .empty(empty0),
        .count(count0), .drop(drop0)
    );

    life_queue #(.DATA_W(DATA_W), .LIFE_W(LIFE_W), .ADDR_LEN(ADDR_LEN), .MODE(1)) u_rotate (
        .clk(clk), .rst(rst), .enq(enq), .deq(deq), .data_in(dataIn),
        .data_out(dataOut1), .out_valid(outValid1), .full(full1), .empty(empty1),
        .count(count1), .drop(drop1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [ENTRY_W-1:0] pack(input int val, input int life);
        return {DATA_W'(val), LIFE_W'(life)};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of requests, then leave outputs settled 1ns past the edge for checking.
    task automatic applyStimulus(input logic e, input logic d, input logic [ENTRY_W-1:0] data);
        @(negedge clk);
        enq    = e;
        deq    = d;
        dataIn = data;
        @(posedge clk);
        #1;
        enq = 1'b0;
        deq = 1'b0;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst    = 1'b0;
        enq    = 1'b0;
        deq    = 1'b0;
        dataIn = '0;
        #2;
        checkOutput("rst_count",    64'(count0),    64'd0);
        checkOutput("rst_empty",    64'(empty0),    64'd1);
        checkOutput("rst_full",     64'(full0),     64'd0);
        checkOutput("rst_dataout",  64'(dataOut0),  64'd0);
        checkOutput("rst_outvalid", 64'(outValid0), 64'd0);
        checkOutput("rst_drop",     64'(drop0),     64'd0);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(1'b1, 1'b1, pack(149, 1));
        checkOutput("bypass_data",  64'(dataOut0),  64'(pack(149, 0)));
        checkOutput("bypass_valid", 64'(outValid0), 64'd1);
        checkOutput("bypass_empty", 64'(empty0),    64'd1);
        checkOutput("bypass_rot",   64'(dataOut1),  64'(pack(149, 0)));
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("hold_valid",   64'(outValid0), 64'd0);
        checkOutput("hold_data",    64'(dataOut0),  64'(pack(149, 0)));

        applyStimulus(1'b1, 1'b0, pack(42, 3));
        applyStimulus(1'b1, 1'b0, pack(27, 1));
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("stk_deq1", 64'(dataOut0), 64'(pack(42, 2)));
        checkOutput("rot_deq1", 64'(dataOut1), 64'(pack(42, 2)));
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("stk_deq2", 64'(dataOut0), 64'(pack(42, 1)));
        checkOutput("rot_deq2", 64'(dataOut1), 64'(pack(27, 0)));
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("stk_deq3", 64'(dataOut0), 64'(pack(42, 0)));
        checkOutput("rot_deq3", 64'(dataOut1), 64'(pack(42, 1)));
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("stk_deq4",   64'(dataOut0), 64'(pack(27, 0)));
        checkOutput("stk_empty4", 64'(empty0),   64'd1);
        checkOutput("rot_deq4",   64'(dataOut1), 64'(pack(42, 0)));
        checkOutput("rot_empty4", 64'(empty1),   64'd1);

        applyStimulus(1'b1, 1'b0, pack(42, 2));
        applyStimulus(1'b1, 1'b0, pack(27, 2));
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("rot2_deq1", 64'(dataOut1), 64'(pack(42, 1)));
        checkOutput("stk2_deq1", 64'(dataOut0), 64'(pack(42, 1)));
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("rot2_deq2", 64'(dataOut1), 64'(pack(27, 1)));
        checkOutput("stk2_deq2", 64'(dataOut0), 64'(pack(42, 0)));
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("rot2_deq3", 64'(dataOut1), 64'(pack(42, 0)));
        checkOutput("stk2_deq3", 64'(dataOut0), 64'(pack(27, 1)));
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("rot2_deq4",  64'(dataOut1), 64'(pack(27, 0)));
        checkOutput("stk2_deq4",  64'(dataOut0), 64'(pack(27, 0)));
        checkOutput("rot2_count", 64'(count1),   64'd0);
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("idle_deq_valid", 64'(outValid0), 64'd0);

        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 1'b0, pack(i, 1));
        end
        checkOutput("fill_full",  64'(full0),  64'd1);
        checkOutput("fill_count", 64'(count0), 64'd4);
        applyStimulus(1'b1, 1'b0, pack(5, 1));
        checkOutput("over_drop",  64'(drop0),  64'd1);
        checkOutput("over_count", 64'(count0), 64'd4);
        applyStimulus(1'b1, 1'b1, pack(6, 1));
        checkOutput("swap_drop",  64'(drop0),    64'd0);
        checkOutput("swap_count", 64'(count0),   64'd4);
        checkOutput("swap_data",  64'(dataOut0), 64'(pack(1, 0)));
        checkOutput("swap_rot",   64'(count1),   64'd4);
        applyStimulus(1'b0, 1'b1, '0);
        applyStimulus(1'b0, 1'b1, '0);
        applyStimulus(1'b0, 1'b1, '0);
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("wrap_last",  64'(dataOut0), 64'(pack(6, 0)));
        checkOutput("wrap_empty", 64'(empty0),   64'd1);

        applyStimulus(1'b1, 1'b0, pack(7, 3));
        applyStimulus(1'b1, 1'b0, pack(8, 1));
        applyStimulus(1'b1, 1'b0, pack(9, 1));
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("pre_rst_count", 64'(count0),   64'd3);
        checkOutput("pre_rst_data",  64'(dataOut0), 64'(pack(7, 2)));
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_count", 64'(count0),   64'd0);
        checkOutput("mid_rst_empty", 64'(empty0),   64'd1);
        checkOutput("mid_rst_data",  64'(dataOut0), 64'd0);
        checkOutput("mid_rst_rot",   64'(count1),   64'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("post_rst_valid", 64'(outValid0), 64'd0);
        checkOutput("post_rst_count", 64'(count0),    64'd0);

        applyStimulus(1'b1, 1'b0, pack(7, 3));
        applyStimulus(1'b1, 1'b0, pack(8, 1));
        applyStimulus(1'b1, 1'b0, pack(9, 1));
        applyStimulus(1'b1, 1'b0, pack(10, 1));
        applyStimulus(1'b1, 1'b1, pack(11, 1));
        checkOutput("stk_full_drop",  64'(drop0),    64'd1);
        checkOutput("stk_full_data",  64'(dataOut0), 64'(pack(7, 2)));
        checkOutput("stk_full_count", 64'(count0),   64'd4);
        checkOutput("rot_full_drop",  64'(drop1),    64'd1);
        checkOutput("rot_full_count", 64'(count1),   64'd4);
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("stk_after_full", 64'(dataOut0), 64'(pack(7, 1)));
        checkOutput("rot_after_full", 64'(dataOut1), 64'(pack(8, 0)));

        pulseReset();
        applyStimulus(1'b1, 1'b1, pack(12, 0));
        checkOutput("zero_bypass_data",  64'(dataOut0),  64'(pack(12, 0)));
        checkOutput("zero_bypass_valid", 64'(outValid0), 64'd1);
        checkOutput("zero_bypass_count", 64'(count0),    64'd0);
        applyStimulus(1'b1, 1'b1, pack(13, 2));
        checkOutput("store_bypass_data",  64'(dataOut0), 64'(pack(13, 1)));
        checkOutput("store_bypass_count", 64'(count0),   64'd1);
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("store_bypass_deq",   64'(dataOut0), 64'(pack(13, 0)));
        checkOutput("store_bypass_empty", 64'(empty0),   64'd1);
        applyStimulus(1'b1, 1'b0, pack(14, 0));
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("zero_stored_deq",   64'(dataOut0), 64'(pack(14, 0)));
        checkOutput("zero_stored_empty", 64'(empty0),   64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
